// File: rtl/dcache_warmup_pkg.sv
// Shared sizing and FSM encoding for the dcache warmup controller.
package dcache_warmup_pkg;

   localparam int SETS     = 64;
   localparam int WAYS     = 4;
   localparam int TAG_BITS = 22;
   localparam int BEATS    = 8;

   localparam int SET_W    = $clog2(SETS);
   localparam int WAY_W    = $clog2(WAYS);
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int BEAT_DW  = 64;
   localparam int LINES_W  = 9;
   localparam int TAG_DW   = TAG_BITS * WAYS;
   localparam int DATA_DW  = BEAT_DW * WAYS;
   localparam int DMASK_W  = 8 * WAYS;
   localparam int DADDR_W  = SET_W + BEAT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/dcache_warmup_lane_pack.sv
// Places one way-lane of write data into a multi-way array word
// and builds the matching per-way write mask.
module dcache_warmup_lane_pack #(
   parameter int LANE_W    = 64,
   parameter int LANES     = 4,
   parameter int MASK_W    = 8,
   parameter bit REPLICATE = 1'b0
) (
   input  logic [LANE_W-1:0]         lane_data,
   input  logic [$clog2(LANES)-1:0]  way,
   output logic [LANE_W*LANES-1:0]   wdata,
   output logic [MASK_W*LANES-1:0]   wmask
);

   localparam int WW = $clog2(LANES);

   always_comb begin
      wdata = '0;
      wmask = '0;
      for (int i = 0; i < LANES; i++) begin
         if (REPLICATE || way == WW'(i)) begin
            wdata[i*LANE_W +: LANE_W] = lane_data;
         end
         if (way == WW'(i)) begin
            wmask[i*MASK_W +: MASK_W] = '1;
         end
      end
   end

endmodule

// File: rtl/dcache_warmup_ctrl.sv
// Streams tag+data beats into the dcache arrays while holding the
// dcache off them; otherwise passes the dcache ports straight through.
module dcache_warmup_ctrl #(
   parameter int SETS     = dcache_warmup_pkg::SETS,
   parameter int WAYS     = dcache_warmup_pkg::WAYS,
   parameter int TAG_BITS = dcache_warmup_pkg::TAG_BITS,
   parameter int BEATS    = dcache_warmup_pkg::BEATS
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err,
   output logic [8:0]                            lines_written,
   input  logic                                  warm_valid,
   output logic                                  warm_ready,
   input  logic [$clog2(SETS)-1:0]               warm_set,
   input  logic [$clog2(WAYS)-1:0]               warm_way,
   input  logic [63:0]                           warm_payload,
   input  logic                                  warm_last,
   input  logic [$clog2(SETS)-1:0]               cache_tag_addr,
   input  logic                                  cache_tag_en,
   input  logic                                  cache_tag_wmode,
   input  logic [TAG_BITS*WAYS-1:0]              cache_tag_wdata,
   input  logic [WAYS-1:0]                       cache_tag_wmask,
   input  logic [$clog2(SETS)+$clog2(BEATS)-1:0] cache_data_addr,
   input  logic                                  cache_data_en,
   input  logic                                  cache_data_wmode,
   input  logic [64*WAYS-1:0]                    cache_data_wdata,
   input  logic [8*WAYS-1:0]                     cache_data_wmask,
   output logic                                  cache_stall,
   output logic [$clog2(SETS)-1:0]               tag_RW0_addr,
   output logic                                  tag_RW0_en,
   output logic                                  tag_RW0_wmode,
   output logic [TAG_BITS*WAYS-1:0]              tag_RW0_wdata,
   output logic [WAYS-1:0]                       tag_RW0_wmask,
   output logic [$clog2(SETS)+$clog2(BEATS)-1:0] data_RW0_addr,
   output logic                                  data_RW0_en,
   output logic                                  data_RW0_wmode,
   output logic [64*WAYS-1:0]                    data_RW0_wdata,
   output logic [8*WAYS-1:0]                     data_RW0_wmask
);

   import dcache_warmup_pkg::*;

   localparam int SW = $clog2(SETS);
   localparam int WW = $clog2(WAYS);
   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   state_e               state_q, state_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [SW-1:0]        set_q, set_d;
   logic [WW-1:0]        way_q, way_d;
   logic                 err_q, err_d;
   logic [LINES_W-1:0]   lines_q, lines_d;
   logic                 tag_wr_q, tag_wr_d;
   logic                 data_wr_q, data_wr_d;
   logic [BW-1:0]        wr_beat_q, wr_beat_d;
   logic [BEAT_DW-1:0]   wr_pay_q, wr_pay_d;

   logic [TAG_BITS*WAYS-1:0] tag_wdata;
   logic [WAYS-1:0]          tag_wmask;
   logic [64*WAYS-1:0]       data_wdata;
   logic [8*WAYS-1:0]        data_wmask;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      set_d     = set_q;
      way_d     = way_q;
      err_d     = err_q;
      lines_d   = lines_q;
      tag_wr_d  = 1'b0;
      data_wr_d = 1'b0;
      wr_beat_d = wr_beat_q;
      wr_pay_d  = wr_pay_q;
      unique case (state_q)
         IDLE: if (start) state_d = TAG;
         TAG: begin
            if (warm_valid) begin
               if (warm_last) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  tag_wr_d = 1'b1;
                  set_d    = warm_set;
                  way_d    = warm_way;
                  wr_pay_d = warm_payload;
                  beat_d   = '0;
                  state_d  = DATA;
               end
            end
         end
         DATA: begin
            if (warm_valid) begin
               if (beat_q == LAST_BEAT) begin
                  data_wr_d = 1'b1;
                  wr_beat_d = beat_q;
                  wr_pay_d  = warm_payload;
                  beat_d    = '0;
                  if (lines_q != '1) lines_d = lines_q + 1'b1;
                  state_d   = warm_last ? DONE : TAG;
               end else if (warm_last) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  data_wr_d = 1'b1;
                  wr_beat_d = beat_q;
                  wr_pay_d  = warm_payload;
                  beat_d    = beat_q + 1'b1;
               end
            end
         end
         DONE: if (start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         set_q     <= '0;
         way_q     <= '0;
         err_q     <= 1'b0;
         lines_q   <= '0;
         tag_wr_q  <= 1'b0;
         data_wr_q <= 1'b0;
         wr_beat_q <= '0;
         wr_pay_q  <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         set_q     <= set_d;
         way_q     <= way_d;
         err_q     <= err_d;
         lines_q   <= lines_d;
         tag_wr_q  <= tag_wr_d;
         data_wr_q <= data_wr_d;
         wr_beat_q <= wr_beat_d;
         wr_pay_q  <= wr_pay_d;
      end
   end

   // set_q/way_q are latched on the tag beat, so they stay valid
   // through the registered write of every beat in the line
   dcache_warmup_lane_pack #(
      .LANE_W(TAG_BITS), .LANES(WAYS), .MASK_W(1), .REPLICATE(1'b1)
   ) u_tag_pack (
      .lane_data(wr_pay_q[TAG_BITS-1:0]),
      .way(way_q),
      .wdata(tag_wdata),
      .wmask(tag_wmask)
   );

   dcache_warmup_lane_pack #(
      .LANE_W(BEAT_DW), .LANES(WAYS), .MASK_W(8), .REPLICATE(1'b0)
   ) u_data_pack (
      .lane_data(wr_pay_q),
      .way(way_q),
      .wdata(data_wdata),
      .wmask(data_wmask)
   );

   assign busy          = (state_q == TAG) || (state_q == DATA);
   assign warm_ready    = busy;
   assign done          = (state_q == DONE);
   assign err           = err_q;
   assign lines_written = lines_q;
   assign cache_stall   = busy || tag_wr_q || data_wr_q;

   always_comb begin
      if (cache_stall) begin
         tag_RW0_addr   = set_q;
         tag_RW0_en     = tag_wr_q;
         tag_RW0_wmode  = 1'b1;
         tag_RW0_wdata  = tag_wdata;
         tag_RW0_wmask  = tag_wmask;
         data_RW0_addr  = {set_q, wr_beat_q};
         data_RW0_en    = data_wr_q;
         data_RW0_wmode = 1'b1;
         data_RW0_wdata = data_wdata;
         data_RW0_wmask = data_wmask;
      end else begin
         tag_RW0_addr   = cache_tag_addr;
         tag_RW0_en     = cache_tag_en;
         tag_RW0_wmode  = cache_tag_wmode;
         tag_RW0_wdata  = cache_tag_wdata;
         tag_RW0_wmask  = cache_tag_wmask;
         data_RW0_addr  = cache_data_addr;
         data_RW0_en    = cache_data_en;
         data_RW0_wmode = cache_data_wmode;
         data_RW0_wdata = cache_data_wdata;
         data_RW0_wmask = cache_data_wmask;
      end
   end

endmodule

// File: tb/tb_dcache_warmup_ctrl.sv
// Directed bench for dcache_warmup_ctrl: expected array writes are
// queued by the stimulus and matched by a negedge monitor.
module tb_dcache_warmup_ctrl;

   logic         clk = 1'b0;
   logic         reset, start;
   logic         busy, done, err;
   logic [8:0]   lines_written;
   logic         warm_valid, warm_ready, warm_last;
   logic [5:0]   warm_set;
   logic [1:0]   warm_way;
   logic [63:0]  warm_payload;
   logic [5:0]   cache_tag_addr;
   logic         cache_tag_en, cache_tag_wmode;
   logic [87:0]  cache_tag_wdata;
   logic [3:0]   cache_tag_wmask;
   logic [8:0]   cache_data_addr;
   logic         cache_data_en, cache_data_wmode;
   logic [255:0] cache_data_wdata;
   logic [31:0]  cache_data_wmask;
   logic         cache_stall;
   logic [5:0]   tag_RW0_addr;
   logic         tag_RW0_en, tag_RW0_wmode;
   logic [87:0]  tag_RW0_wdata;
   logic [3:0]   tag_RW0_wmask;
   logic [8:0]   data_RW0_addr;
   logic         data_RW0_en, data_RW0_wmode;
   logic [255:0] data_RW0_wdata;
   logic [31:0]  data_RW0_wmask;

   always #5 clk = ~clk;

   dcache_warmup_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .busy(busy), .done(done), .err(err),
      .lines_written(lines_written),
      .warm_valid(warm_valid), .warm_ready(warm_ready),
      .warm_set(warm_set), .warm_way(warm_way),
      .warm_payload(warm_payload), .warm_last(warm_last),
      .cache_tag_addr(cache_tag_addr), .cache_tag_en(cache_tag_en),
      .cache_tag_wmode(cache_tag_wmode),
      .cache_tag_wdata(cache_tag_wdata),
      .cache_tag_wmask(cache_tag_wmask),
      .cache_data_addr(cache_data_addr), .cache_data_en(cache_data_en),
      .cache_data_wmode(cache_data_wmode),
      .cache_data_wdata(cache_data_wdata),
      .cache_data_wmask(cache_data_wmask),
      .cache_stall(cache_stall),
      .tag_RW0_addr(tag_RW0_addr), .tag_RW0_en(tag_RW0_en),
      .tag_RW0_wmode(tag_RW0_wmode), .tag_RW0_wdata(tag_RW0_wdata),
      .tag_RW0_wmask(tag_RW0_wmask),
      .data_RW0_addr(data_RW0_addr), .data_RW0_en(data_RW0_en),
      .data_RW0_wmode(data_RW0_wmode), .data_RW0_wdata(data_RW0_wdata),
      .data_RW0_wmask(data_RW0_wmask)
   );

   typedef struct {
      logic        is_tag;
      logic [8:0]  addr;
      logic [1:0]  way;
      logic [63:0] d;
   } wr_t;

   wr_t          exp_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   int           wr_cnt = 0;
   int           first_wr = -1;
   int           last_wr = -1;
   logic [87:0]  last_tag_wdata = '0;
   wr_t          m_e;
   logic [106:0] m_obs, m_exp;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (cache_stall && (tag_RW0_en || data_RW0_en)) begin
         wr_cnt++;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (tag_RW0_en) last_tag_wdata = tag_RW0_wdata;
         if (tag_RW0_en && data_RW0_en)
            chk("dual_wr", {tag_RW0_en, data_RW0_en}, 2'b01);
         if (exp_q.size() == 0) begin
            chk("unexp_wr", {tag_RW0_en, data_RW0_en}, 2'b00);
         end else begin
            m_e = exp_q.pop_front();
            if (tag_RW0_en)
               m_obs = {tag_RW0_wmode, 1'b1, {3'b000, tag_RW0_addr},
                        32'(tag_RW0_wmask),
                        64'(tag_RW0_wdata[22*m_e.way +: 22])};
            else
               m_obs = {data_RW0_wmode, 1'b0, data_RW0_addr,
                        data_RW0_wmask,
                        data_RW0_wdata[64*m_e.way +: 64]};
            m_exp = {1'b1, m_e.is_tag, m_e.addr,
                     m_e.is_tag ? 32'(4'b0001 << m_e.way)
                                : (32'hFF << (8*m_e.way)),
                     m_e.d};
            chk("wr", 128'(m_obs), 128'(m_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [5:0] s, input logic [1:0] w,
                       input logic [63:0] p, input logic l);
      int n;
      n = 0;
      warm_valid   = 1'b1;
      warm_set     = s;
      warm_way     = w;
      warm_payload = p;
      warm_last    = l;
      while (!warm_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) chk("ready_tmo", warm_ready, 1);
      tick();
      warm_valid = 1'b0;
      warm_last  = 1'b0;
   endtask

   task automatic push(input logic t, input logic [8:0] a,
                       input logic [1:0] w, input logic [63:0] d);
      wr_t e;
      e.is_tag = t;
      e.addr   = a;
      e.way    = w;
      e.d      = d;
      exp_q.push_back(e);
   endtask

   task automatic send_tag(input logic [5:0] s, input logic [1:0] w,
                           input logic [21:0] t);
      push(1'b1, {3'b000, s}, w, 64'(t));
      send(s, w, 64'(t), 1'b0);
   endtask

   task automatic send_data(input logic [5:0] s, input logic [1:0] w,
                            input logic [2:0] b, input logic [63:0] d,
                            input logic l);
      push(1'b0, {s, b}, w, d);
      send(s, w, d, l);
   endtask

   task automatic line(input logic [5:0] s, input logic [1:0] w,
                       input logic l);
      send_tag(s, w, 22'h100000 | 22'({s, w}));
      for (int b = 0; b < 8; b++)
         send_data(s, w, 3'(b), {24'(s), 8'(w), 32'(b)},
                   l && (b == 7));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0;
      warm_valid = 1'b0; warm_last = 1'b0;
      warm_set = '0; warm_way = '0; warm_payload = '0;
      cache_tag_addr = '0; cache_tag_en = 1'b0; cache_tag_wmode = 1'b0;
      cache_tag_wdata = '0; cache_tag_wmask = '0;
      cache_data_addr = '0; cache_data_en = 1'b0; cache_data_wmode = 1'b0;
      cache_data_wdata = '0; cache_data_wmask = '0;
      tick();
      do_reset();

      chk("rst_flags", {busy, done, err, warm_ready, cache_stall,
                        tag_RW0_en, data_RW0_en}, 7'b0);
      chk("rst_lines", lines_written, 9'd0);

      // single line
      do_start();
      chk("t1_busy", {busy, warm_ready, cache_stall}, 3'b111);
      send_tag(6'd5, 2'd2, 22'h2ABCDE);
      for (int b = 0; b < 8; b++)
         send_data(6'd5, 2'd2, 3'(b), 64'h11 * 64'(b + 1), b == 7);
      chk("t1_done", {done, busy, cache_stall, err}, 4'b1010);
      chk("t1_lines", lines_written, 9'd1);
      tick();
      chk("t1_stall", cache_stall, 1'b0);
      chk("t1_tagwd", last_tag_wdata, {4{22'h2ABCDE}});
      chk("t1_q", exp_q.size(), 0);

      // back-to-back lines across every set and way
      do_reset();
      wr_cnt = 0; first_wr = -1; last_wr = -1;
      do_start();
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++)
            line(6'(s), 2'(w), (s == 63) && (w == 3));
      tick();
      chk("t2_wrcnt", wr_cnt, 2304);
      chk("t2_span", last_wr - first_wr + 1, 2304);
      chk("t2_lines", lines_written, 9'd256);
      chk("t2_done", {done, err}, 2'b10);
      chk("t2_q", exp_q.size(), 0);

      // stall after data beat 3
      do_reset();
      do_start();
      send_tag(6'd3, 2'd1, 22'h0ABC12);
      for (int b = 0; b < 4; b++)
         send_data(6'd3, 2'd1, 3'(b), 64'hA000 + 64'(b), 1'b0);
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("t3_gap", {tag_RW0_en, data_RW0_en, warm_ready}, 3'b001);
      end
      for (int b = 4; b < 8; b++)
         send_data(6'd3, 2'd1, 3'(b), 64'hA000 + 64'(b), b == 7);
      tick();
      chk("t3_end", {done, err, lines_written}, {2'b10, 9'd1});
      chk("t3_q", exp_q.size(), 0);

      // early last on data beat 2
      do_reset();
      do_start();
      send_tag(6'd7, 2'd0, 22'h3FFFFF);
      send_data(6'd7, 2'd0, 3'd0, 64'hDEAD0000, 1'b0);
      send_data(6'd7, 2'd0, 3'd1, 64'hDEAD0001, 1'b0);
      send(6'd7, 2'd0, 64'hDEAD0002, 1'b1);
      chk("t4_err", {err, done, busy, cache_stall}, 4'b1100);
      chk("t4_lines", lines_written, 9'd0);
      tick();
      chk("t4_q", exp_q.size(), 0);
      do_start();
      chk("t4_sticky", {err, done, busy}, 3'b100);

      // passthrough in IDLE, ignored during warmup
      do_reset();
      cache_tag_en = 1'b1; cache_tag_addr = 6'd9; cache_tag_wmode = 1'b1;
      cache_tag_wmask = 4'hA; cache_tag_wdata = 88'h123;
      cache_data_en = 1'b1; cache_data_addr = 9'h1A3;
      cache_data_wmask = 32'hF0F0_0000; cache_data_wdata = 256'h55;
      #1;
      chk("t5_tagpt", {cache_stall, tag_RW0_en, tag_RW0_addr, tag_RW0_wmask},
          {1'b0, 1'b1, 6'd9, 4'hA});
      chk("t5_datapt", {data_RW0_en, data_RW0_addr, data_RW0_wmask},
          {1'b1, 9'h1A3, 32'hF0F0_0000});
      do_start();
      chk("t5_stall", {cache_stall, tag_RW0_en, data_RW0_en}, 3'b100);
      line(6'd9, 2'd3, 1'b1);
      tick();
      chk("t5_back", {cache_stall, tag_RW0_en, tag_RW0_addr},
          {1'b0, 1'b1, 6'd9});
      chk("t5_q", exp_q.size(), 0);
      cache_tag_en = 1'b0; cache_data_en = 1'b0;

      // reset at data beat 4
      do_reset();
      do_start();
      send_tag(6'd12, 2'd3, 22'h00F00F);
      for (int b = 0; b < 4; b++)
         send_data(6'd12, 2'd3, 3'(b), 64'hB000 + 64'(b), 1'b0);
      reset = 1'b1;
      warm_valid = 1'b1; warm_payload = 64'hB004;
      tick();
      chk("t6_flags", {busy, done, err, warm_ready, cache_stall,
                       tag_RW0_en, data_RW0_en}, 7'b0);
      chk("t6_lines", lines_written, 9'd0);
      reset = 1'b0;
      warm_valid = 1'b0;
      repeat (4) tick();
      chk("t6_idle", {busy, cache_stall}, 2'b00);
      chk("t6_q", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dcache_warmup_ctrl.md
DCACHE_WARMUP_CTRL -- requirements
Module: dcache_warmup_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning the number of dcache sets.
REQ-002 SHALL have parameter WAYS, default 4, meaning the number of dcache ways.
REQ-003 SHALL have parameter TAG_BITS, default 22, meaning 20 raw tag bits plus 2 coherency bits.
REQ-004 SHALL have parameter BEATS, default 8, meaning the number of 64-bit data beats per 64B line.
REQ-005 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high.
REQ-006 SHALL have ports: start input 1, a pulse that begins warmup; busy output 1; done output 1; err output 1; lines_written output 9, the count of completed lines.
REQ-007 SHALL have ports: warm_valid input 1; warm_ready output 1; warm_set input 6; warm_way input 2; warm_payload input 64, holding the tag in bits [21:0] on a tag beat and data on a data beat; warm_last input 1, marking the final beat of the final line.
REQ-008 SHALL have ports: cache_tag_{addr 6, en 1, wmode 1, wdata 88, wmask 4} inputs, cache_data_{addr 9, en 1, wmode 1, wdata 256, wmask 32} inputs, and cache_stall output 1, which holds the dcache off the arrays.
REQ-009 SHALL have ports: tag_RW0_{addr 6, en, wmode, wdata 88, wmask 4} outputs and data_RW0_{addr 9, en, wmode, wdata 256, wmask 32} outputs, wired to tag_array_ext and data_arrays_0_ext.

Function
REQ-010 SHALL use the FSM states IDLE, TAG, DATA, DONE, with warm_ready=1 only in TAG and DATA.
REQ-011 SHALL move from IDLE to TAG on start; start in any other state SHALL be ignored.
REQ-012 SHALL treat each line as one tag beat followed by BEATS data beats; TAG goes to DATA on handshake, and DATA goes back to TAG after beat BEATS-1.
REQ-013 SHALL, on a tag-beat handshake, register a tag write on the next cycle: addr=warm_set, wmode=1, wdata = payload[21:0] replicated into every 22-bit way lane, wmask = one-hot(warm_way).
REQ-014 SHALL, on data beat b, register a data write on the next cycle: addr={warm_set,b[2:0]}, wmode=1, wdata = payload in lane warm_way (bits 64*way+:64), wmask = 8'hFF<<(8*way).
REQ-015 SHALL sustain full throughput, accepting one beat per cycle with exactly one array write per accepted beat at 1-cycle latency.
REQ-016 SHALL latch the set and way on the tag beat; warm_set and warm_way on data beats SHALL be ignored.
REQ-017 SHALL increment lines_written after the last data beat of each line and saturate at 511.
REQ-018 SHALL enter DONE when warm_last is accepted on data beat BEATS-1, setting done=1 and busy=0; DONE SHALL return to IDLE on the next start.
REQ-019 SHALL set err=1 (sticky until reset) and go to DONE, with no write issued for that beat, when warm_last is accepted on a tag beat or on a data beat other than BEATS-1.
REQ-020 SHALL, while warm_valid=0, stall in place with no array enable.
REQ-021 SHALL drive cache_stall=busy for states TAG, DATA and for the one registered write cycle after the final beat.
REQ-022 SHALL pass the cache_* inputs through combinationally to the RW0 ports whenever cache_stall=0, and drive the warmup writes or en=0 otherwise.

Reset
REQ-023 SHALL, on reset, set: state IDLE, busy 0, done 0, err 0, lines_written 0, beat counter 0, warm_ready 0, cache_stall 0, and all registered write enables 0.
REQ-024 SHALL, on reset during TAG or DATA, abandon the partial line with no further writes, and SHALL make no attempt to roll back beats already written.

Structure
REQ-025 SHALL place SETS, WAYS, TAG_BITS, BEATS, the derived widths and the FSM state enum in a shared package dcache_warmup_pkg.
REQ-026 SHALL place the way-lane wdata/wmask placement in one combinational sub-module dcache_warmup_lane_pack, instantiated once for tag writes and once for data writes.

Verification
REQ-027 SHALL cover a single line: start, tag beat set=5 way=2 payload=0x2ABCDE, then 8 data beats 0x11..0x88 with last on beat 7 -> tag write addr=5 wmask=4'b0100; data addrs 40..47 with wmask 0x00FF0000; done=1; lines_written=1.
REQ-028 SHALL cover back-to-back lines: 256 lines (all sets x ways) with warm_valid held high -> 2304 consecutive write cycles with no bubbles and lines_written=256.
REQ-029 SHALL cover stalls: warm_valid deasserted for 3 cycles after data beat 3 -> no enables during the gap, and the beat counter resumes at 4.
REQ-030 SHALL cover an early last: warm_last on data beat 2 -> err=1, DONE, no write for that beat, cache_stall falls.
REQ-031 SHALL cover passthrough: in IDLE with cache_tag_en=1, addr=9 -> tag_RW0_addr=9 on the same cycle; during warmup the cache inputs are ignored and cache_stall=1.
REQ-032 SHALL cover reset mid-line: reset asserted at data beat 4 -> next cycle IDLE, all outputs at reset values, no further writes.
